// File: rtl/dm_trace_request_issuer.sv
// Walks stored trace entries in index order, issues one cache request per entry
// through a small tracker table and retires entries on cache completion.
module dm_trace_request_issuer #(
  parameter int unsigned TRACE_ENTRIES    = 65536,
  parameter int unsigned INSTR_DATA_WIDTH = 32,
  parameter int unsigned DATA_ADDR_WIDTH  = 32,
  parameter int unsigned TRACKER_SLOTS    = 4,
  localparam int unsigned IDX_W  = $clog2(TRACE_ENTRIES),
  localparam int unsigned SLOT_W = $clog2(TRACKER_SLOTS)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [IDX_W-1:0]                          trace_count,
  output logic                                      repo_rd_en,
  output logic [IDX_W-1:0]                          repo_rd_addr,
  input  logic [INSTR_DATA_WIDTH+DATA_ADDR_WIDTH-1:0] repo_rd_data,
  output logic                                      req_valid,
  output logic [DATA_ADDR_WIDTH-1:0]                req_addr,
  output logic [IDX_W-1:0]                          req_index,
  input  logic                                      req_ready,
  input  logic                                      done_valid,
  input  logic [IDX_W-1:0]                          done_index,
  output logic                                      busy,
  output logic                                      all_retired,
  output logic                                      error
);

  // state     | meaning
  // IDLE      | waiting for start       FETCH | repo read strobe
  // WAIT_DATA | capture into free slot  ISSUE | request held until ready
  // STALL     | tracker full            DRAIN | wait for last retirement
  // DONE      | one-cycle all_retired pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_DATA, S_ISSUE, S_STALL, S_DRAIN, S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRACE_ENTRIES - 1);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             count_q;
  logic [IDX_W-1:0]             index_q;
  logic [IDX_W-1:0]             index_inc;
  logic [TRACKER_SLOTS-1:0]     occ_q;
  logic [TRACKER_SLOTS-1:0]     proc_q;
  logic [DATA_ADDR_WIDTH-1:0]   addr_q [TRACKER_SLOTS];
  logic [IDX_W-1:0]             tidx_q [TRACKER_SLOTS];
  logic [SLOT_W-1:0]            cur_q;
  logic                         error_q;

  logic                         free_found;
  logic [SLOT_W-1:0]            free_slot;
  logic                         done_hit;
  logic [SLOT_W-1:0]            done_slot;
  logic                         unused_instr;

  assign unused_instr = ^repo_rd_data[INSTR_DATA_WIDTH+DATA_ADDR_WIDTH-1:DATA_ADDR_WIDTH];
  assign index_inc    = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;

  // Both searches look at start-of-cycle occupancy, so an allocation and a
  // retirement in the same cycle can never pick the same slot.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    done_hit   = 1'b0;
    done_slot  = '0;
    for (int i = 0; i < int'(TRACKER_SLOTS); i++) begin
      if (!occ_q[i] && !free_found) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
      if (occ_q[i] && proc_q[i] && (tidx_q[i] == done_index) && !done_hit) begin
        done_hit  = 1'b1;
        done_slot = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = (trace_count == '0) ? S_DONE : S_FETCH;
      S_FETCH:     state_d = S_WAIT_DATA;
      S_WAIT_DATA: state_d = S_ISSUE;
      S_ISSUE: begin
        if (req_ready) begin
          if (index_inc == count_q) state_d = S_DRAIN;
          else if (free_found)      state_d = S_FETCH;
          else                      state_d = S_STALL;
        end
      end
      S_STALL:     if (free_found) state_d = S_FETCH;
      S_DRAIN:     if (occ_q == '0) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    repo_rd_en   = 1'b0;
    repo_rd_addr = '0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_index    = '0;
    all_retired  = 1'b0;
    case (state_q)
      S_FETCH: begin
        repo_rd_en   = 1'b1;
        repo_rd_addr = index_q;
      end
      S_ISSUE: begin
        req_valid = 1'b1;
        req_addr  = addr_q[cur_q];
        req_index = tidx_q[cur_q];
      end
      S_DONE:  all_retired = 1'b1;
      default: ;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign error = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      index_q <= '0;
      occ_q   <= '0;
      proc_q  <= '0;
      cur_q   <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < int'(TRACKER_SLOTS); i++) begin
        addr_q[i] <= '0;
        tidx_q[i] <= '0;
      end
    end else begin
      if (state_q == S_IDLE && start) begin
        count_q <= trace_count;
        index_q <= '0;
      end
      if (state_q == S_WAIT_DATA) begin
        occ_q[free_slot]  <= 1'b1;
        proc_q[free_slot] <= 1'b0;
        addr_q[free_slot] <= repo_rd_data[DATA_ADDR_WIDTH-1:0];
        tidx_q[free_slot] <= index_q;
        cur_q             <= free_slot;
      end
      if (state_q == S_ISSUE && req_ready) begin
        proc_q[cur_q] <= 1'b1;
        index_q       <= index_inc;
      end
      if (done_valid && state_q != S_IDLE) begin
        if (done_hit) begin
          occ_q[done_slot]  <= 1'b0;
          proc_q[done_slot] <= 1'b0;
        end else begin
          error_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_trace_request_issuer.sv
// Directed bench for dm_trace_request_issuer: a cycle table for the basic walk
// plus hand-timed sequences for stall, backpressure, error and reset cases.
module tb_dm_trace_request_issuer;

  localparam int IW = 16;
  localparam int AW = 32;
  localparam bit Y  = 1'b1;
  localparam bit N  = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] trace_count;
  logic          repo_rd_en;
  logic [IW-1:0] repo_rd_addr;
  logic [63:0]   repo_rd_data;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] req_index;
  logic          req_ready;
  logic          done_valid;
  logic [IW-1:0] done_index;
  logic          busy;
  logic          all_retired;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_trace_request_issuer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .trace_count  (trace_count),
    .repo_rd_en   (repo_rd_en),
    .repo_rd_addr (repo_rd_addr),
    .repo_rd_data (repo_rd_data),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_index    (req_index),
    .req_ready    (req_ready),
    .done_valid   (done_valid),
    .done_index   (done_index),
    .busy         (busy),
    .all_retired  (all_retired),
    .error        (error)
  );

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'(32'h1000 + (i << 4));
  endfunction

  // Repository model: data for a strobed index is valid only in the following cycle.
  logic          rd_pend = 1'b0;
  logic [IW-1:0] rd_a    = '0;
  always @(negedge clk) begin
    rd_pend = repo_rd_en;
    rd_a    = repo_rd_addr;
  end
  always @(posedge clk) begin
    #1;
    repo_rd_data = rd_pend ? {32'h0000_0013, addr_of(int'(rd_a))} : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  typedef struct packed {
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic          rv;
    logic [AW-1:0] ra;
    logic [IW-1:0] ri;
    logic          bsy;
    logic          ar;
    logic          err;
  } outs_t;

  typedef struct {
    logic          st;
    logic [IW-1:0] cnt;
    logic          rdy;
    logic          dv;
    logic [IW-1:0] di;
    outs_t         exp;
  } vec_t;

  function automatic outs_t mk(input bit en, input int rda, input bit rv, input int ra,
                               input int ri, input bit b, input bit ar, input bit er);
    outs_t o;
    o.rd_en   = en;
    o.rd_addr = IW'(rda);
    o.rv      = rv;
    o.ra      = AW'(ra);
    o.ri      = IW'(ri);
    o.bsy     = b;
    o.ar      = ar;
    o.err     = er;
    return o;
  endfunction

  task automatic chk(input string name, input outs_t exp);
    outs_t act;
    act = {repo_rd_en, repo_rd_addr, req_valid, req_addr, req_index, busy, all_retired, error};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rd_en=%0b rd_addr=%0h req_valid=%0b req_addr=%0h req_index=%0h busy=%0b all_retired=%0b error=%0b ; expected rd_en=%0b rd_addr=%0h req_valid=%0b req_addr=%0h req_index=%0h busy=%0b all_retired=%0b error=%0b",
               name, act.rd_en, act.rd_addr, act.rv, act.ra, act.ri, act.bsy, act.ar, act.err,
               exp.rd_en, exp.rd_addr, exp.rv, exp.ra, exp.ri, exp.bsy, exp.ar, exp.err);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic done(input int idx);
    done_valid = 1'b1;
    done_index = IW'(idx);
    tick();
    done_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{Y, 16'd1, Y, N, 16'd0, mk(N, 0, N, 0,      0, N, N, N)};
    vecs[1]  = '{N, 16'd0, Y, N, 16'd0, mk(Y, 0, N, 0,      0, Y, N, N)};
    vecs[2]  = '{N, 16'd0, Y, N, 16'd0, mk(N, 0, N, 0,      0, Y, N, N)};
    vecs[3]  = '{N, 16'd0, Y, N, 16'd0, mk(N, 0, Y, 'h1000, 0, Y, N, N)};
    vecs[4]  = '{N, 16'd0, Y, N, 16'd0, mk(N, 0, N, 0,      0, Y, N, N)};
    vecs[5]  = '{N, 16'd0, Y, Y, 16'd0, mk(N, 0, N, 0,      0, Y, N, N)};
    vecs[6]  = '{N, 16'd0, Y, N, 16'd0, mk(N, 0, N, 0,      0, Y, N, N)};
    vecs[7]  = '{N, 16'd0, Y, N, 16'd0, mk(N, 0, N, 0,      0, Y, Y, N)};
    vecs[8]  = '{N, 16'd0, Y, N, 16'd0, mk(N, 0, N, 0,      0, N, N, N)};
    vecs[9]  = '{Y, 16'd0, Y, N, 16'd0, mk(N, 0, N, 0,      0, N, N, N)};
    vecs[10] = '{N, 16'd0, Y, N, 16'd0, mk(N, 0, N, 0,      0, Y, Y, N)};
    vecs[11] = '{N, 16'd0, Y, Y, 16'd5, mk(N, 0, N, 0,      0, N, N, N)};
    vecs[12] = '{N, 16'd0, N, N, 16'd0, mk(N, 0, N, 0,      0, N, N, N)};

    rst_n       = 1'b0;
    start       = 1'b0;
    trace_count = '0;
    req_ready   = 1'b0;
    done_valid  = 1'b0;
    done_index  = '0;
    ticks(2);
    chk("reset_state", mk(N, 0, N, 0, 0, N, N, N));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single entry walk, empty walk, completion in IDLE
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("vec%0d", k), vecs[k].exp);
      start       = vecs[k].st;
      trace_count = vecs[k].cnt;
      req_ready   = vecs[k].rdy;
      done_valid  = vecs[k].dv;
      done_index  = vecs[k].di;
      tick();
    end

    // six entries, four slots, no completions until stalled; restart ignored
    start = 1'b1; trace_count = 16'd6; req_ready = 1'b1;
    tick(); start = 1'b0;
    chk("t2_fetch0", mk(Y, 0, N, 0, 0, Y, N, N));
    start = 1'b1; trace_count = 16'd2;
    tick(); start = 1'b0;
    tick();
    chk("t2_req0", mk(N, 0, Y, addr_of(0), 0, Y, N, N));
    for (int k = 1; k < 4; k++) begin
      ticks(3);
      chk($sformatf("t2_req%0d", k), mk(N, 0, Y, addr_of(k), k, Y, N, N));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t2_stall%0d", k), mk(N, 0, N, 0, 0, Y, N, N));
    end
    done(2);
    chk("t2_stall_after_done", mk(N, 0, N, 0, 0, Y, N, N));
    tick();
    chk("t2_fetch4", mk(Y, 4, N, 0, 0, Y, N, N));
    ticks(2);
    chk("t2_req4", mk(N, 0, Y, addr_of(4), 4, Y, N, N));
    tick();
    chk("t2_stall_full", mk(N, 0, N, 0, 0, Y, N, N));
    done(0);
    chk("t2_stall_last", mk(N, 0, N, 0, 0, Y, N, N));
    tick();
    chk("t2_fetch5", mk(Y, 5, N, 0, 0, Y, N, N));
    ticks(2);
    chk("t2_req5", mk(N, 0, Y, addr_of(5), 5, Y, N, N));
    tick();
    chk("t2_drain", mk(N, 0, N, 0, 0, Y, N, N));
    done(1); done(3); done(4); done(5);
    chk("t2_drain_end", mk(N, 0, N, 0, 0, Y, N, N));
    tick();
    chk("t2_retired", mk(N, 0, N, 0, 0, Y, Y, N));
    tick();
    chk("t2_idle", mk(N, 0, N, 0, 0, N, N, N));

    // backpressure for five cycles, then an unmatched completion
    start = 1'b1; trace_count = 16'd2; req_ready = 1'b0;
    tick(); start = 1'b0;
    ticks(2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_hold%0d", k), mk(N, 0, Y, addr_of(0), 0, Y, N, N));
      tick();
    end
    chk("t3_hold_last", mk(N, 0, Y, addr_of(0), 0, Y, N, N));
    req_ready = 1'b1;
    tick();
    chk("t3_fetch1", mk(Y, 1, N, 0, 0, Y, N, N));
    ticks(2);
    chk("t3_req1", mk(N, 0, Y, addr_of(1), 1, Y, N, N));
    tick();
    chk("t3_drain", mk(N, 0, N, 0, 0, Y, N, N));
    done(9);
    chk("t4_error_set", mk(N, 0, N, 0, 0, Y, N, Y));
    done(0); done(1);
    chk("t4_drain_end", mk(N, 0, N, 0, 0, Y, N, Y));
    tick();
    chk("t4_retired", mk(N, 0, N, 0, 0, Y, Y, Y));
    tick();
    chk("t4_idle_sticky", mk(N, 0, N, 0, 0, N, N, Y));

    // reset mid-walk with three slots occupied
    start = 1'b1; trace_count = 16'd6; req_ready = 1'b1;
    tick(); start = 1'b0;
    ticks(8);
    chk("t6_req2", mk(N, 0, Y, addr_of(2), 2, Y, N, Y));
    tick();
    chk("t6_fetch3", mk(Y, 3, N, 0, 0, Y, N, Y));
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", mk(N, 0, N, 0, 0, N, N, N));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_idle", mk(N, 0, N, 0, 0, N, N, N));
    start = 1'b1; trace_count = 16'd1;
    tick(); start = 1'b0;
    chk("t6_refetch0", mk(Y, 0, N, 0, 0, Y, N, N));
    ticks(2);
    chk("t6_rereq0", mk(N, 0, Y, addr_of(0), 0, Y, N, N));
    tick();
    done(0);
    chk("t6_drain", mk(N, 0, N, 0, 0, Y, N, N));
    tick();
    chk("t6_retired", mk(N, 0, N, 0, 0, Y, Y, N));
    tick();
    chk("t6_final_idle", mk(N, 0, N, 0, 0, N, N, N));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_trace_request_issuer.md
Name: dm_trace_request_issuer

Overview:
Read-side counterpart of the direct-mapped trace repository.
- Walks stored trace entries (instruction, mem_addr) in index order from 0.
- Issues one memory request per entry to the cache with a valid/ready handshake.
- Tracks in-flight requests in a small tracker table (occupied, mem_addr, processing, trace_index).
- Retires each entry when the cache reports completion; signals when the whole trace is retired.

Parameters:
TRACE_ENTRIES, 65536, repository depth; IDX_W = $clog2(TRACE_ENTRIES)
INSTR_DATA_WIDTH, 32, instruction field width
DATA_ADDR_WIDTH, 32, memory address width
TRACKER_SLOTS, 4, maximum outstanding requests (power of two, at least 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse: begin walk at index 0
trace_count  in  IDX_W  number of valid entries, sampled on accepted start
repo_rd_en  out  1  repository read strobe
repo_rd_addr  out  IDX_W  repository read index
repo_rd_data  in  INSTR_DATA_WIDTH+DATA_ADDR_WIDTH  {instruction, mem_addr}, valid the cycle after repo_rd_en
req_valid  out  1  request to cache
req_addr  out  DATA_ADDR_WIDTH  request address
req_index  out  IDX_W  trace index of request
req_ready  in  1  cache accepts request
done_valid  in  1  cache completion strobe
done_index  in  IDX_W  trace index completed
busy  out  1  walk in progress (state != IDLE)
all_retired  out  1  one-cycle pulse: every entry retired
error  out  1  sticky: unmatched completion

Behaviour:
- Reset (async, rst_n low): state IDLE; all slots free; index counter 0; all outputs 0; error cleared. Reset mid-walk abandons all in-flight requests with no retirement pulse.
- States and transitions:
  - IDLE: start=1 latches trace_count and clears the index. Count 0 -> DONE; otherwise -> FETCH. start is ignored in every other state.
  - FETCH (entered only when a free slot exists): repo_rd_en=1, repo_rd_addr=index for exactly one cycle -> WAIT_DATA.
  - WAIT_DATA: capture repo_rd_data into the lowest-numbered free slot. Slot becomes occupied=1, processing=0 (MAKE_REQUEST), trace_index=index. -> ISSUE.
  - ISSUE: req_valid=1; req_addr and req_index are taken from the slot and held stable until req_ready. On handshake: processing=1 (WAIT_FOR_PROCESSING), index++. Then:
    - index == count -> DRAIN;
    - else a free slot exists -> FETCH;
    - else -> STALL.
  - STALL: -> FETCH on the first cycle a free slot exists.
  - DRAIN: -> DONE on the cycle no slot is occupied.
  - DONE: all_retired=1 for one cycle -> IDLE.
- Latency: start sampled at cycle T -> repo_rd_en at T+1 -> slot written at T+2 -> req_valid at T+3. Steady state with req_ready tied high: one request every 3 cycles.
- Completion (any state except IDLE):
  - done_valid frees the slot with occupied && processing && trace_index == done_index (REQUEST_RETIRED); that slot is free the next cycle.
  - No match, or a match to a slot with processing=0: set error, change nothing.
  - Completions in IDLE are ignored, and error is not set.
- Simultaneous events:
  - A completion and a slot allocation in the same cycle never target the same slot; the free-slot search uses start-of-cycle state.
  - A completion freeing the last slot in STALL moves to FETCH the next cycle.
- Index counter wraps modulo TRACE_ENTRIES. trace_count=0 means empty; a full walk of TRACE_ENTRIES entries is not supported.
- Duplicate mem_addr values across slots are allowed; no coalescing.
- The instruction field is dropped at capture.

Test Plan:
- Reset then start, trace_count=1, entry {0x00000013, 0x00001000}, req_ready=1 -> repo_rd_en at T+1 with addr 0; req_valid at T+3 with req_addr=0x1000, req_index=0; done_valid/done_index=0 two cycles later -> all_retired pulse, busy falls.
- trace_count=6, TRACKER_SLOTS=4, no done_valid -> exactly 4 requests (indices 0-3), then STALL with repo_rd_en=0. done_index=2 -> next request is index 4, written into slot 2.
- req_ready held low 5 cycles in ISSUE -> req_valid, req_addr and req_index stable all 5 cycles; index advances only on the handshake cycle.
- done_index=9 while only indices 0-1 are in flight -> error=1 and stays set, slots unchanged; the walk still completes after valid completions.
- start with trace_count=0 -> all_retired pulses at T+1, no repo_rd_en or req_valid. A second start asserted while busy -> ignored, trace_count not relatched.
- rst_n asserted low mid-walk with 3 slots occupied -> all outputs 0 immediately (async); after release, start re-walks from index 0.
